// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline stall/flush controller with held branch redirects and exception/ERET sequencing
module pipeline_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hbfc0_0380,
    parameter int          FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_stall_req_i,
    input  logic        id_stall_req_i,
    input  logic        exe_stall_req_i,
    input  logic        data_stall_req_i,
    input  logic        branch_enable_i,
    input  logic [31:0] branch_addr_i,
    input  logic        exc_req_i,
    input  logic        eret_i,
    input  logic [31:0] epc_i,
    output logic [3:0]  stall_o,
    output logic        flush_o,
    output logic        branch_enable_o,
    output logic [31:0] branch_addr_o,
    output logic        busy_o,
    output logic [31:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    // Down-counter reload: counting reaches zero on the last flush cycle.
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t      state;
    logic        pend;
    logic [31:0] pend_addr;
    logic [31:0] target;
    logic [3:0]  flush_cnt;
    logic [31:0] stall_cnt;
    logic [3:0]  idle_stall;
    logic        accept;

    // Highest stalled stage wins; a stall freezes its stage and everything upstream.
    always_comb begin
        idle_stall = 4'b0000;
        if (data_stall_req_i)      idle_stall = 4'b1111;
        else if (exe_stall_req_i)  idle_stall = 4'b0111;
        else if (id_stall_req_i)   idle_stall = 4'b0011;
        else if (inst_stall_req_i) idle_stall = 4'b0001;
    end

    // Exceptions/ERET may only commit once MEM is not waiting on data.
    assign accept = (state == IDLE) && (exc_req_i || eret_i) && !data_stall_req_i;

    // Outputs decode from state and inputs; reset forces everything quiet.
    always_comb begin
        stall_o         = 4'b0000;
        flush_o         = 1'b0;
        branch_enable_o = 1'b0;
        branch_addr_o   = 32'h0;
        busy_o          = 1'b0;
        stall_cnt_o     = 32'h0;
        if (!rst) begin
            stall_cnt_o = stall_cnt;
            case (state)
                IDLE: begin
                    stall_o         = idle_stall;
                    branch_enable_o = pend || branch_enable_i;
                    branch_addr_o   = pend ? pend_addr : branch_addr_i;
                end
                FLUSH: begin
                    stall_o       = 4'b0001;
                    flush_o       = 1'b1;
                    busy_o        = 1'b1;
                    branch_addr_o = target;
                end
                REDIRECT: begin
                    branch_enable_o = 1'b1;
                    branch_addr_o   = target;
                    busy_o          = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // FSM, flush down-counter, pending branch and saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pend      <= 1'b0;
            pend_addr <= 32'h0;
            target    <= 32'h0;
            flush_cnt <= 4'd0;
            stall_cnt <= 32'h0;
        end else begin
            if ((stall_o != 4'b0000) && (stall_cnt != 32'hffff_ffff))
                stall_cnt <= stall_cnt + 32'd1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= FLUSH;
                        target    <= exc_req_i ? EXC_VECTOR : epc_i;
                        flush_cnt <= FLUSH_LOAD;
                        pend      <= 1'b0;
                    end else if (pend && (idle_stall == 4'b0000)) begin
                        pend <= 1'b0;
                    end else if (!pend && branch_enable_i && (idle_stall != 4'b0000)) begin
                        pend      <= 1'b1;
                        pend_addr <= branch_addr_i;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == 4'd0) state <= REDIRECT;
                    else                   flush_cnt <= flush_cnt - 4'd1;
                end
                REDIRECT: begin
                    state <= IDLE;
                    pend  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, id_req, exe_req, data_req;
    logic        br_en;
    logic [31:0] br_addr;
    logic        exc, eret;
    logic [31:0] epc;

    logic [3:0]  d_stall, q_stall;
    logic        d_flush, q_flush, d_ben, q_ben, d_busy, q_busy;
    logic [31:0] d_addr, q_addr, d_cnt, q_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.EXC_VECTOR(32'hbfc0_0380), .FLUSH_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .inst_stall_req_i(inst_req), .id_stall_req_i(id_req),
        .exe_stall_req_i(exe_req), .data_stall_req_i(data_req),
        .branch_enable_i(br_en), .branch_addr_i(br_addr),
        .exc_req_i(exc), .eret_i(eret), .epc_i(epc),
        .stall_o(d_stall), .flush_o(d_flush), .branch_enable_o(d_ben),
        .branch_addr_o(d_addr), .busy_o(d_busy), .stall_cnt_o(d_cnt)
    );

    pipeline_ctrl #(.EXC_VECTOR(32'hbfc0_0380), .FLUSH_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst),
        .inst_stall_req_i(inst_req), .id_stall_req_i(id_req),
        .exe_stall_req_i(exe_req), .data_stall_req_i(data_req),
        .branch_enable_i(br_en), .branch_addr_i(br_addr),
        .exc_req_i(exc), .eret_i(eret), .epc_i(epc),
        .stall_o(q_stall), .flush_o(q_flush), .branch_enable_o(q_ben),
        .branch_addr_o(q_addr), .busy_o(q_busy), .stall_cnt_o(q_cnt)
    );

    typedef struct {
        logic        r;
        logic [3:0]  req;     // {data, exe, id, inst}
        logic        be;
        logic [31:0] ba;
        logic        ex;
        logic        er;
        logic [31:0] ep;
        logic [3:0]  es;
        logic        ef;
        logic        eb;
        logic [31:0] ea;      // compared only when eb is set
        logic        ebusy;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic vec_t mk(logic r, logic [3:0] req, logic be, logic [31:0] ba,
                                logic ex, logic er, logic [31:0] ep, logic [3:0] es,
                                logic ef, logic eb, logic [31:0] ea, logic ebusy);
        vec_t v;
        v.r = r; v.req = req; v.be = be; v.ba = ba; v.ex = ex; v.er = er; v.ep = ep;
        v.es = es; v.ef = ef; v.eb = eb; v.ea = ea; v.ebusy = ebusy;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        inst_req = 0; id_req = 0; exe_req = 0; data_req = 0;
        br_en = 0; br_addr = 32'h0; exc = 0; eret = 0; epc = 32'h0;
    endtask

    // Drive one vector, queue its expectation, compare mid-cycle, advance.
    task automatic step(vec_t v, int idx);
        vec_t e;
        rst = v.r;
        {data_req, exe_req, id_req, inst_req} = v.req;
        br_en = v.be; br_addr = v.ba; exc = v.ex; eret = v.er; epc = v.ep;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        chk($sformatf("v%0d.stall", idx), {28'h0, d_stall}, {28'h0, e.es});
        chk($sformatf("v%0d.flush", idx), {31'h0, d_flush}, {31'h0, e.ef});
        chk($sformatf("v%0d.ben", idx), {31'h0, d_ben}, {31'h0, e.eb});
        if (e.eb) chk($sformatf("v%0d.baddr", idx), d_addr, e.ea);
        chk($sformatf("v%0d.busy", idx), {31'h0, d_busy}, {31'h0, e.ebusy});
        chk($sformatf("v%0d.cnt", idx), d_cnt, e.r ? 32'h0 : exp_cnt);
        if (e.r) exp_cnt = 0;
        else if (e.es != 4'b0000) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] EV = 32'hbfc0_0380;

    initial begin
        rst = 1;
        clear_inputs();
        //             r  req      be ba            ex er ep            es       ef eb ea            busy
        tbl.push_back(mk(1, 4'b1111, 1, 32'h1111_1111, 1, 1, 32'h2, 4'b0000, 0, 0, 32'h0, 0));
        tbl.push_back(mk(1, 4'b0000, 0, 32'h0, 0, 0, 32'h0, 4'b0000, 0, 0, 32'h0, 0));
        // stall priority
        tbl.push_back(mk(0, 4'b0110, 0, 32'h0, 0, 0, 32'h0, 4'b0111, 0, 0, 32'h0, 0));
        tbl.push_back(mk(0, 4'b1000, 0, 32'h0, 0, 0, 32'h0, 4'b1111, 0, 0, 32'h0, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 32'h0, 0, 0, 32'h0, 4'b0000, 0, 0, 32'h0, 0));
        tbl.push_back(mk(0, 4'b0001, 0, 32'h0, 0, 0, 32'h0, 4'b0001, 0, 0, 32'h0, 0));
        tbl.push_back(mk(0, 4'b0010, 0, 32'h0, 0, 0, 32'h0, 4'b0011, 0, 0, 32'h0, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 32'h0, 0, 0, 32'h0, 4'b0000, 0, 0, 32'h0, 0));
        // branch held through an exe stall
        tbl.push_back(mk(0, 4'b0100, 1, 32'hbfc0_0100, 0, 0, 32'h0, 4'b0111, 0, 1, 32'hbfc0_0100, 0));
        tbl.push_back(mk(0, 4'b0100, 0, 32'hdead_beef, 0, 0, 32'h0, 4'b0111, 0, 1, 32'hbfc0_0100, 0));
        tbl.push_back(mk(0, 4'b0100, 0, 32'hdead_beef, 0, 0, 32'h0, 4'b0111, 0, 1, 32'hbfc0_0100, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 32'h0, 0, 0, 32'h0, 4'b0000, 0, 1, 32'hbfc0_0100, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 32'h0, 0, 0, 32'h0, 4'b0000, 0, 0, 32'h0, 0));
        // second branch while pending does not overwrite
        tbl.push_back(mk(0, 4'b0010, 1, 32'hbfc0_0200, 0, 0, 32'h0, 4'b0011, 0, 1, 32'hbfc0_0200, 0));
        tbl.push_back(mk(0, 4'b0010, 1, 32'hbfc0_0300, 0, 0, 32'h0, 4'b0011, 0, 1, 32'hbfc0_0200, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 32'h0, 0, 0, 32'h0, 4'b0000, 0, 1, 32'hbfc0_0200, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 32'h0, 0, 0, 32'h0, 4'b0000, 0, 0, 32'h0, 0));
        // unstalled branch passes straight through
        tbl.push_back(mk(0, 4'b0000, 1, 32'hbfc0_0400, 0, 0, 32'h0, 4'b0000, 0, 1, 32'hbfc0_0400, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 32'h0, 0, 0, 32'h0, 4'b0000, 0, 0, 32'h0, 0));
        // exception: accept, flush (requests ignored), redirect
        tbl.push_back(mk(0, 4'b0000, 0, 32'h0, 1, 0, 32'h0, 4'b0000, 0, 0, 32'h0, 0));
        tbl.push_back(mk(0, 4'b0100, 0, 32'h0, 1, 0, 32'h0, 4'b0001, 1, 0, 32'h0, 1));
        tbl.push_back(mk(0, 4'b0000, 0, 32'h0, 1, 0, 32'h0, 4'b0000, 0, 1, EV, 1));
        tbl.push_back(mk(0, 4'b0000, 0, 32'h0, 0, 0, 32'h0, 4'b0000, 0, 0, 32'h0, 0));
        // ERET blocked by data stall, then accepted
        tbl.push_back(mk(0, 4'b1000, 0, 32'h0, 0, 1, 32'hbfc0_1234, 4'b1111, 0, 0, 32'h0, 0));
        tbl.push_back(mk(0, 4'b1000, 0, 32'h0, 0, 1, 32'hbfc0_1234, 4'b1111, 0, 0, 32'h0, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 32'h0, 0, 1, 32'hbfc0_1234, 4'b0000, 0, 0, 32'h0, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 32'h0, 0, 0, 32'h0, 4'b0001, 1, 0, 32'h0, 1));
        tbl.push_back(mk(0, 4'b0000, 0, 32'h0, 0, 0, 32'h0, 4'b0000, 0, 1, 32'hbfc0_1234, 1));
        tbl.push_back(mk(0, 4'b0000, 0, 32'h0, 0, 0, 32'h0, 4'b0000, 0, 0, 32'h0, 0));
        // exception beats ERET
        tbl.push_back(mk(0, 4'b0000, 0, 32'h0, 1, 1, 32'h5555_5555, 4'b0000, 0, 0, 32'h0, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 32'h0, 0, 0, 32'h0, 4'b0001, 1, 0, 32'h0, 1));
        tbl.push_back(mk(0, 4'b0000, 0, 32'h0, 0, 0, 32'h0, 4'b0000, 0, 1, EV, 1));
        tbl.push_back(mk(0, 4'b0000, 0, 32'h0, 0, 0, 32'h0, 4'b0000, 0, 0, 32'h0, 0));
        // pending branch dropped on flush entry
        tbl.push_back(mk(0, 4'b0100, 1, 32'hbfc0_0600, 0, 0, 32'h0, 4'b0111, 0, 1, 32'hbfc0_0600, 0));
        tbl.push_back(mk(0, 4'b0100, 0, 32'h0, 1, 0, 32'h0, 4'b0111, 0, 1, 32'hbfc0_0600, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 32'h0, 0, 0, 32'h0, 4'b0001, 1, 0, 32'h0, 1));
        tbl.push_back(mk(0, 4'b0000, 0, 32'h0, 0, 0, 32'h0, 4'b0000, 0, 1, EV, 1));
        tbl.push_back(mk(0, 4'b0000, 0, 32'h0, 0, 0, 32'h0, 4'b0000, 0, 0, 32'h0, 0));

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

        // FLUSH_CYCLES=4 instance: four flush cycles then a redirect
        clear_inputs();
        rst = 1;
        @(posedge clk); #1;
        rst = 0; exc = 1;
        @(posedge clk); #1;
        exc = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("f4.flush%0d", k), {31'h0, q_flush}, 32'h1);
            chk($sformatf("f4.stall%0d", k), {28'h0, q_stall}, 32'h1);
            chk($sformatf("f4.ben%0d", k), {31'h0, q_ben}, 32'h0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("f4.redir_ben", {31'h0, q_ben}, 32'h1);
        chk("f4.redir_addr", q_addr, EV);
        chk("f4.redir_flush", {31'h0, q_flush}, 32'h0);
        chk("f4.redir_busy", {31'h0, q_busy}, 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("f4.idle_busy", {31'h0, q_busy}, 32'h0);
        chk("f4.cnt", q_cnt, 32'd4);
        @(posedge clk); #1;

        // reset during the second flush cycle
        rst = 1;
        @(posedge clk); #1;
        rst = 0; exc = 1;
        @(posedge clk); #1;
        exc = 0;
        @(negedge clk);
        chk("rf.flush1", {31'h0, q_flush}, 32'h1);
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        chk("rf.rst_stall", {28'h0, q_stall}, 32'h0);
        chk("rf.rst_flush", {31'h0, q_flush}, 32'h0);
        chk("rf.rst_ben", {31'h0, q_ben}, 32'h0);
        chk("rf.rst_addr", q_addr, 32'h0);
        chk("rf.rst_busy", {31'h0, q_busy}, 32'h0);
        chk("rf.rst_cnt", q_cnt, 32'h0);
        @(posedge clk); #1;
        rst = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("rf.busy%0d", k), {31'h0, q_busy}, 32'h0);
            chk($sformatf("rf.flush%0d", k), {31'h0, q_flush}, 32'h0);
            chk($sformatf("rf.ben%0d", k), {31'h0, q_ben}, 32'h0);
            chk($sformatf("rf.cnt%0d", k), q_cnt, 32'h0);
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
